player_grid_engine: RTL and testbench
=====================================

# player_grid_engine

Command-driven position and wall register bank for NUM_PLAYERS players on a GRID_W x GRID_H board, replacing the fixed two-player, per-bit-enabled coordinate registers. It accepts one move or placement command at a time, bounds- and collision-checks it against all player locations and placed walls, and commits it only if legal. It returns a status code and exposes all coordinates to the renderer and game FSM.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of players (2..8)
- COORD_W, 4, coordinate width in bits
- GRID_W, 8, board width in cells (≤ 2^COORD_W)
- GRID_H, 8, board height in cells (≤ 2^COORD_W)
- PID_W, 3, player-index width (≥ clog2(NUM_PLAYERS))

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_player  in  PID_W  target player index
- cmd_op  in  3  0 UP (y-1), 1 DOWN (y+1), 2 LEFT (x-1), 3 RIGHT (x+1), 4 SET_LOC, 5 PLACE_WALL, 6/7 illegal
- cmd_x, cmd_y  in  COORD_W  absolute coordinate for ops 4/5
- rsp_valid  out  1  one-cycle response pulse
- rsp_status  out  2  0 OK, 1 OUT_OF_BOUNDS, 2 COLLISION, 3 ILLEGAL
- loc_x, loc_y  out  NUM_PLAYERS*COORD_W  packed player locations, player i at [i*COORD_W +: COORD_W]
- wall_x, wall_y  out  NUM_PLAYERS*COORD_W  packed last-placed wall per player, same packing
- wall_vld  out  NUM_PLAYERS  wall i has been placed

## Operation
- FSM: IDLE -> CHECK -> RESP -> IDLE. A command is accepted on an edge with cmd_valid && cmd_ready; cmd fields are latched. CHECK always lasts one cycle, RESP always one cycle.
- CHECK computes the target cell: moves use current loc ± 1, computed in COORD_W+1 bits to detect underflow/overflow; ops 4/5 use latched cmd_x/cmd_y.
- Status priority is ILLEGAL > OUT_OF_BOUNDS > COLLISION > OK.
- ILLEGAL: op 6/7 or cmd_player ≥ NUM_PLAYERS.
- OUT_OF_BOUNDS: target x ≥ GRID_W or y ≥ GRID_H, or a move below 0.
- COLLISION for moves and SET_LOC: target equals the loc of any other player, or any valid wall (including own).
- COLLISION for PLACE_WALL: target equals any player's loc (including own), or another player's valid wall. Re-placing onto own wall cell is OK.
- Collision is checked against state before this command; only one player's state changes per command.
- On the edge leaving CHECK: if status OK, update the target player's loc (ops 0-4) or wall_x/wall_y and set wall_vld (op 5). Otherwise all state is unchanged. rsp_status is registered on the same edge.
- RESP: rsp_valid=1 and rsp_status is valid. There is no backpressure on the response.
- Reset values: all loc/wall coordinates 0, wall_vld 0, rsp_valid 0, rsp_status 0, FSM IDLE, cmd_ready 1.

## Timing
- Acceptance at edge E0. The CHECK cycle follows. At edge E1, state and rsp_status are updated and rsp_valid rises. At edge E2, rsp_valid falls and cmd_ready rises.
- Latency from acceptance to response is 2 cycles. Throughput is one command per 3 cycles.
- New loc/wall outputs are visible in the same cycle as rsp_valid.
- cmd_ready is low during CHECK and RESP. cmd_valid is ignored while cmd_ready is low; the requester holds the command.
- clrn asserted at any time forces all registers to reset values immediately. An in-flight command is dropped with no response and no state change. The first edge after clrn deasserts may accept a command.

## Configuration
- GRID_WRAP_EN defined: moves wrap toroidally.
  - x=0 LEFT gives x=GRID_W-1; x=GRID_W-1 RIGHT gives 0. Y wraps the same way with GRID_H.
  - A wrapped move is never OUT_OF_BOUNDS; collision is checked on the wrapped cell.
  - SET_LOC and PLACE_WALL with out-of-range coordinates still return OUT_OF_BOUNDS.
- GRID_WRAP_EN undefined: any move leaving the board returns OUT_OF_BOUNDS and the player does not move.

## Test plan
All scenarios use default parameters.
- Reset, then SET_LOC p0 (3,5) -> rsp_valid 2 cycles after accept, status 0, loc p0 = (3,5), cmd_ready low for 2 cycles.
- p0 at (0,2), LEFT -> without GRID_WRAP_EN: status 1, loc stays (0,2). With GRID_WRAP_EN: status 0, loc (7,2).
- p0 at (3,4), p1 at (4,4), p0 RIGHT -> status 2, p0 stays (3,4). Then p0 UP -> status 0, p0 = (3,3).
- p1 PLACE_WALL (6,6) -> status 0, wall_vld = 2'b10. Then p0 at (6,5), DOWN -> status 2. Then p0 PLACE_WALL (6,5) -> status 2 (own loc).
- cmd_player=2 with op 0 -> status 3. Op 7 with cmd_player=0 -> status 3. In both cases, no loc/wall change.
- Accept SET_LOC p1 (1,1), assert clrn during CHECK -> no rsp_valid, all outputs 0, loc p1 = (0,0), cmd_ready 1 after release.

Source files
------------

// File: rtl/player_grid_engine.sv
// player_grid_engine: command-driven location and wall register bank for
// NUM_PLAYERS players on a GRID_W x GRID_H board. Each command is latched,
// bounds/collision checked for one cycle, committed only if legal, and
// answered with a one-cycle status pulse.
// Optional feature: define GRID_WRAP_EN to make moves wrap toroidally.
//
// Handshake: a command is taken on any rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so the requester
// holds the command until then. rsp_valid is a single-cycle pulse with no
// backpressure; rsp_status is valid exactly while rsp_valid is high.
module player_grid_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 4,
  parameter int GRID_W      = 8,
  parameter int GRID_H      = 8,
  parameter int PID_W       = 3
) (
  input  logic                           clk,
  input  logic                           clrn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [PID_W-1:0]               cmd_player,
  input  logic [2:0]                     cmd_op,
  input  logic [COORD_W-1:0]             cmd_x,
  input  logic [COORD_W-1:0]             cmd_y,
  output logic                           rsp_valid,
  output logic [1:0]                     rsp_status,
  output logic [NUM_PLAYERS*COORD_W-1:0] loc_x,
  output logic [NUM_PLAYERS*COORD_W-1:0] loc_y,
  output logic [NUM_PLAYERS*COORD_W-1:0] wall_x,
  output logic [NUM_PLAYERS*COORD_W-1:0] wall_y,
  output logic [NUM_PLAYERS-1:0]         wall_vld,
  output logic [1:0]                     dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, RESP = 2'd2} state_t;

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W:0] GW = CW1'(GRID_W);
  localparam logic [COORD_W:0] GH = CW1'(GRID_H);

  localparam logic [2:0] OP_UP    = 3'd0;
  localparam logic [2:0] OP_DOWN  = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_SET   = 3'd4;
  localparam logic [2:0] OP_WALL  = 3'd5;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_OOB  = 2'd1;
  localparam logic [1:0] ST_COLL = 2'd2;
  localparam logic [1:0] ST_ILL  = 2'd3;

  state_t               state;
  logic [PID_W-1:0]     lat_player;
  logic [2:0]           lat_op;
  logic [COORD_W-1:0]   lat_x, lat_y;

  logic [COORD_W-1:0]   loc_x_r [NUM_PLAYERS];
  logic [COORD_W-1:0]   loc_y_r [NUM_PLAYERS];
  logic [COORD_W-1:0]   wall_x_r[NUM_PLAYERS];
  logic [COORD_W-1:0]   wall_y_r[NUM_PLAYERS];

  logic [COORD_W-1:0]   cur_x, cur_y;
  logic [COORD_W:0]     cx, cy, tx, ty;
  logic                 ill, oob, coll;
  logic [1:0]           chk_status;

  // Target cell and status for the latched command, against pre-command state.
  always_comb begin
    cur_x = '0;
    cur_y = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (PID_W'(i) == lat_player) begin
        cur_x = loc_x_r[i];
        cur_y = loc_y_r[i];
      end
    end
    cx = {1'b0, cur_x};
    cy = {1'b0, cur_y};
    tx = cx;
    ty = cy;
    // One extra bit: a move below 0 shows up as a value >= the board size.
    case (lat_op)
`ifdef GRID_WRAP_EN
      OP_UP:    ty = (cy == '0) ? GH - CW1'(1) : cy - CW1'(1);
      OP_DOWN:  ty = (cy == GH - CW1'(1)) ? '0 : cy + CW1'(1);
      OP_LEFT:  tx = (cx == '0) ? GW - CW1'(1) : cx - CW1'(1);
      OP_RIGHT: tx = (cx == GW - CW1'(1)) ? '0 : cx + CW1'(1);
`else
      OP_UP:    ty = cy - CW1'(1);
      OP_DOWN:  ty = cy + CW1'(1);
      OP_LEFT:  tx = cx - CW1'(1);
      OP_RIGHT: tx = cx + CW1'(1);
`endif
      default: begin
        tx = {1'b0, lat_x};
        ty = {1'b0, lat_y};
      end
    endcase

    ill = (lat_op > OP_WALL) || (int'(lat_player) >= NUM_PLAYERS);
    oob = (tx >= GW) || (ty >= GH);

    coll = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (lat_op == OP_WALL) begin
        // Walls may not cover any player; re-placing onto own wall is fine.
        if (tx == {1'b0, loc_x_r[i]} && ty == {1'b0, loc_y_r[i]})
          coll = 1'b1;
        if (wall_vld[i] && (PID_W'(i) != lat_player) &&
            tx == {1'b0, wall_x_r[i]} && ty == {1'b0, wall_y_r[i]})
          coll = 1'b1;
      end else begin
        if ((PID_W'(i) != lat_player) &&
            tx == {1'b0, loc_x_r[i]} && ty == {1'b0, loc_y_r[i]})
          coll = 1'b1;
        if (wall_vld[i] &&
            tx == {1'b0, wall_x_r[i]} && ty == {1'b0, wall_y_r[i]})
          coll = 1'b1;
      end
    end

    if (ill)       chk_status = ST_ILL;
    else if (oob)  chk_status = ST_OOB;
    else if (coll) chk_status = ST_COLL;
    else           chk_status = ST_OK;
  end

  // Command FSM with registered handshake/response outputs and state commit.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      lat_player <= '0;
      lat_op     <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      wall_vld   <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        loc_x_r[i]  <= '0;
        loc_y_r[i]  <= '0;
        wall_x_r[i] <= '0;
        wall_y_r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            lat_player <= cmd_player;
            lat_op     <= cmd_op;
            lat_x      <= cmd_x;
            lat_y      <= cmd_y;
            cmd_ready  <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          rsp_status <= chk_status;
          rsp_valid  <= 1'b1;
          state      <= RESP;
          if (chk_status == ST_OK) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (PID_W'(i) == lat_player) begin
                if (lat_op == OP_WALL) begin
                  wall_x_r[i] <= tx[COORD_W-1:0];
                  wall_y_r[i] <= ty[COORD_W-1:0];
                  wall_vld[i] <= 1'b1;
                end else begin
                  loc_x_r[i] <= tx[COORD_W-1:0];
                  loc_y_r[i] <= ty[COORD_W-1:0];
                end
              end
            end
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign loc_x [g*COORD_W +: COORD_W] = loc_x_r[g];
    assign loc_y [g*COORD_W +: COORD_W] = loc_y_r[g];
    assign wall_x[g*COORD_W +: COORD_W] = wall_x_r[g];
    assign wall_y[g*COORD_W +: COORD_W] = wall_y_r[g];
  end

endmodule

// File: tb/tb_player_grid_engine.sv
// Bench for player_grid_engine: directed scenarios plus random commands,
// predicted by a board-level model and checked by a response monitor.
module tb_player_grid_engine;

  localparam int NP = 2;
  localparam int CW = 4;
  localparam int GW = 8;
  localparam int GH = 8;
  localparam int PW = 3;
  localparam int W  = 2 + 4*NP*CW + NP;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn = 1'b1;
  always #5 clk = ~clk;

  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [PW-1:0]        cmd_player = '0;
  logic [2:0]           cmd_op = '0;
  logic [CW-1:0]        cmd_x = '0, cmd_y = '0;
  logic                 rsp_valid;
  logic [1:0]           rsp_status;
  logic [NP*CW-1:0]     loc_x, loc_y, wall_x, wall_y;
  logic [NP-1:0]        wall_vld;
  logic [1:0]           dbg_state;

  player_grid_engine #(.NUM_PLAYERS(NP), .COORD_W(CW), .GRID_W(GW),
                       .GRID_H(GH), .PID_W(PW)) dut (
    .clk(clk), .clrn(clrn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_player(cmd_player), .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .loc_x(loc_x), .loc_y(loc_y), .wall_x(wall_x), .wall_y(wall_y),
    .wall_vld(wall_vld), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int neg_cnt = 0;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  // ---------------- reference model ----------------
  int mx[NP], my[NP], wx[NP], wy[NP];
  bit wv[NP];

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      mx[i] = 0; my[i] = 0; wx[i] = 0; wy[i] = 0; wv[i] = 0;
    end
  endfunction

  // Applies one command to the board and returns its status code.
  function automatic logic [1:0] model_apply(int p, int op, int x, int y);
    int tx, ty;
    bit coll;
    if (op > 5 || p >= NP) return 2'd3;
    if (op < 4) begin
      tx = mx[p]; ty = my[p];
      case (op)
        0: ty = ty - 1;
        1: ty = ty + 1;
        2: tx = tx - 1;
        default: tx = tx + 1;
      endcase
`ifdef GRID_WRAP_EN
      tx = (tx + GW) % GW;
      ty = (ty + GH) % GH;
`endif
    end else begin
      tx = x; ty = y;
    end
    if (tx < 0 || tx >= GW || ty < 0 || ty >= GH) return 2'd1;
    coll = 0;
    for (int j = 0; j < NP; j++) begin
      if (op == 5) begin
        if (mx[j] == tx && my[j] == ty) coll = 1;
        if (j != p && wv[j] && wx[j] == tx && wy[j] == ty) coll = 1;
      end else begin
        if (j != p && mx[j] == tx && my[j] == ty) coll = 1;
        if (wv[j] && wx[j] == tx && wy[j] == ty) coll = 1;
      end
    end
    if (coll) return 2'd2;
    if (op == 5) begin
      wx[p] = tx; wy[p] = ty; wv[p] = 1;
    end else begin
      mx[p] = tx; my[p] = ty;
    end
    return 2'd0;
  endfunction

  function automatic logic [W-1:0] model_pack(logic [1:0] st);
    logic [NP*CW-1:0] lx, ly, ax, ay;
    logic [NP-1:0]    v;
    for (int i = 0; i < NP; i++) begin
      lx[i*CW +: CW] = CW'(mx[i]);
      ly[i*CW +: CW] = CW'(my[i]);
      ax[i*CW +: CW] = CW'(wx[i]);
      ay[i*CW +: CW] = CW'(wy[i]);
      v[i] = wv[i];
    end
    return {st, lx, ly, ax, ay, v};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    int acc;
    neg_cnt++;
    if (!clrn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 status=%0d, required no response", rsp_status);
      end else begin
        exp_v = exp_q.pop_front();
        acc = acc_q.pop_front();
        act_v = {rsp_status, loc_x, loc_y, wall_x, wall_y, wall_vld};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL rsp_state: got status=%0d state=%h, required status=%0d state=%h",
                   act_v[W-1 -: 2], act_v, exp_v[W-1 -: 2], exp_v);
        end
        checks++;
        if (neg_cnt - acc != 2) begin
          errors++;
          $display("FAIL rsp_latency: got %0d cycles, required 2", neg_cnt - acc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_ready(input string name, input logic req);
    checks++;
    if (cmd_ready !== req) begin
      errors++;
      $display("FAIL %s: cmd_ready=%0b required %0b", name, cmd_ready, req);
    end
  endtask

  task automatic issue(input int p, input int op, input int x, input int y);
    int n;
    logic [1:0] st;
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_ready("ready_idle", 1'b1);
    cmd_valid  = 1'b1;
    cmd_player = PW'(p);
    cmd_op     = 3'(op);
    cmd_x      = CW'(x);
    cmd_y      = CW'(y);
    @(posedge clk);
    st = model_apply(p, op, x, y);
    exp_q.push_back(model_pack(st));
    acc_q.push_back(neg_cnt);
    #1;
    cmd_valid  = 1'b0;
    cmd_player = PW'($urandom_range(0, 7));
    cmd_op     = 3'($urandom_range(0, 7));
    cmd_x      = CW'($urandom_range(0, 15));
    cmd_y      = CW'($urandom_range(0, 15));
    @(negedge clk);
    check_ready("ready_check", 1'b0);
    @(negedge clk);
    check_ready("ready_resp", 1'b0);
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({rsp_valid, rsp_status, loc_x, loc_y, wall_x, wall_y, wall_vld} !== '0 ||
        cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: rsp_valid=%0b status=%0d loc=%h/%h wall=%h/%h vld=%b ready=%0b, required all 0 and ready 1",
               name, rsp_valid, rsp_status, loc_x, loc_y, wall_x, wall_y, wall_vld, cmd_ready);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_state");

    issue(0, 4, 3, 5);            // SET_LOC p0 (3,5)
    issue(0, 4, 0, 2);            // p0 to (0,2)
    issue(0, 2, 0, 0);            // LEFT at edge: OOB or wrap
    issue(0, 4, 3, 4);
    issue(1, 4, 4, 4);
    issue(0, 3, 0, 0);            // RIGHT into p1: collision
    issue(0, 0, 0, 0);            // UP: ok -> (3,3)
    issue(1, 5, 6, 6);            // p1 wall (6,6)
    issue(0, 4, 6, 5);
    issue(0, 1, 0, 0);            // DOWN into wall: collision
    issue(0, 5, 6, 5);            // wall on own loc: collision
    issue(1, 5, 6, 6);            // re-place onto own wall: ok
    issue(2, 0, 0, 0);            // bad player: illegal
    issue(0, 7, 0, 0);            // bad op: illegal
    issue(0, 4, 8, 0);            // SET_LOC x out of range
    issue(0, 5, 0, 8);            // PLACE_WALL y out of range
    issue(0, 4, 7, 0);
    issue(0, 3, 0, 0);            // RIGHT off east edge
    issue(0, 0, 0, 0);            // UP off north edge
    issue(0, 4, 2, 7);
    issue(0, 1, 0, 0);            // DOWN off south edge

    // Reset during CHECK drops the in-flight command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_player = 3'd1; cmd_op = 3'd4; cmd_x = 4'd1; cmd_y = 4'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    @(negedge clk);
    check_idle_zero("reset_in_check");
    clrn = 1'b0;
    @(negedge clk);
    check_idle_zero("after_release");

    for (int k = 0; k < 200; k++) begin
      int p, op;
      p  = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 7) : $urandom_range(0, NP-1);
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
      issue(p, op, $urandom_range(0, 9), $urandom_range(0, 9));
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
